// File: rtl/write_route_ctrl.sv
// write_route_ctrl
//   Write-channel routing controller placed in front of the AXI4-Lite write
//   demultiplexer. Decodes the slave index from AWADDR, drives a registered
//   demux select that is held for the whole AW/W/B transaction, gates the
//   master's AWVALID/WVALID/BREADY into the demux and returns the selected
//   slave's AWREADY/WREADY/BVALID/BRESP. Indices 6 and 7 complete locally
//   with DECERR.
//
// Ports
//   ACLK, ARESETN                  clock, asynchronous active-low reset
//   M00_AWADDR/AWVALID/AWREADY     master write-address channel
//   M00_WVALID/WREADY              master write-data channel handshake
//   M00_BVALID/BRESP/BREADY        master write-response channel
//   sel                            registered demux select (slave index)
//   FWD_AWVALID/WVALID/BREADY      gated master signals into the demux
//   S_AWREADY/WREADY/BVALID        per-slave handshakes, bit i = slave i
//   S_BRESP                        per-slave responses, slave i at [RESP*i +: RESP]
module write_route_ctrl #(
  parameter int unsigned ADDR     = 32,
  parameter int unsigned SLOT_LSB = 12,
  parameter int unsigned RESP     = 2
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR-1:0]   M00_AWADDR,
  input  logic              M00_AWVALID,
  output logic              M00_AWREADY,
  input  logic              M00_WVALID,
  output logic              M00_WREADY,
  output logic              M00_BVALID,
  output logic [RESP-1:0]   M00_BRESP,
  input  logic              M00_BREADY,
  output logic [2:0]        sel,
  output logic              FWD_AWVALID,
  output logic              FWD_WVALID,
  output logic              FWD_BREADY,
  input  logic [5:0]        S_AWREADY,
  input  logic [5:0]        S_WREADY,
  input  logic [5:0]        S_BVALID,
  input  logic [6*RESP-1:0] S_BRESP
);

  localparam int unsigned     NUM_SLAVES = 6;
  localparam logic [RESP-1:0] DECERR     = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            err;
  logic            aw_done;
  logic            w_done;
  logic [2:0]      idx;
  logic            idx_ok;
  logic            aw_hs;
  logic            w_hs;
  logic            sl_awready;
  logic            sl_wready;
  logic            sl_bvalid;
  logic [RESP-1:0] sl_bresp;
  logic            unused_addr;

  assign idx         = M00_AWADDR[SLOT_LSB+2:SLOT_LSB];
  assign idx_ok      = (idx < 3'(NUM_SLAVES));
  assign unused_addr = ^M00_AWADDR;

  // Handshakes as seen by the master; only consumed by the state register.
  assign aw_hs = M00_AWVALID & M00_AWREADY;
  assign w_hs  = M00_WVALID & M00_WREADY;

  // Return-path mux from the currently selected slave.
  always_comb begin
    sl_awready = 1'b0;
    sl_wready  = 1'b0;
    sl_bvalid  = 1'b0;
    sl_bresp   = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel == 3'(i)) begin
        sl_awready = S_AWREADY[i];
        sl_wready  = S_WREADY[i];
        sl_bvalid  = S_BVALID[i];
        sl_bresp   = S_BRESP[RESP*i +: RESP];
      end
    end
  end

  // Next state and all combinational outputs. The DATA exit condition uses
  // the handshakes recomputed locally so this block never reads back one of
  // its own outputs through a separate net.
  always_comb begin
    state_nxt   = state;
    M00_AWREADY = 1'b0;
    M00_WREADY  = 1'b0;
    M00_BVALID  = 1'b0;
    M00_BRESP   = '0;
    FWD_AWVALID = 1'b0;
    FWD_WVALID  = 1'b0;
    FWD_BREADY  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (M00_AWVALID) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (err) begin
          M00_AWREADY = ~aw_done;
          M00_WREADY  = ~w_done;
        end else begin
          FWD_AWVALID = M00_AWVALID & ~aw_done;
          FWD_WVALID  = M00_WVALID & ~w_done;
          M00_AWREADY = sl_awready & ~aw_done;
          M00_WREADY  = sl_wready & ~w_done;
        end
        if ((aw_done | (M00_AWVALID & M00_AWREADY)) &
            (w_done  | (M00_WVALID  & M00_WREADY)))
          state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (err) begin
          M00_BVALID = 1'b1;
          M00_BRESP  = DECERR;
        end else begin
          M00_BVALID = sl_bvalid;
          M00_BRESP  = sl_bresp;
          FWD_BREADY = M00_BREADY;
        end
        if (M00_BVALID & M00_BREADY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= ST_IDLE;
      sel     <= '0;
      err     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (M00_AWVALID) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            // An undecodable index keeps the previous select so the demux
            // never sees a change it has no slave for.
            if (idx_ok) begin
              sel <= idx;
              err <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_write_route_ctrl.sv
// Testbench for write_route_ctrl: directed scenarios followed by randomized
// transactions. Every B handshake is checked against an expected {sel, resp}
// queued when the transaction was issued; during the random phase the
// per-cycle channel behaviour is also checked against the routing rules.
module tb_write_route_ctrl;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] M00_AWADDR;
  logic        M00_AWVALID;
  logic        M00_AWREADY;
  logic        M00_WVALID;
  logic        M00_WREADY;
  logic        M00_BVALID;
  logic [1:0]  M00_BRESP;
  logic        M00_BREADY;
  logic [2:0]  sel;
  logic        FWD_AWVALID;
  logic        FWD_WVALID;
  logic        FWD_BREADY;
  logic [5:0]  S_AWREADY;
  logic [5:0]  S_WREADY;
  logic [5:0]  S_BVALID;
  logic [11:0] S_BRESP;

  write_route_ctrl #(.ADDR(32), .SLOT_LSB(12), .RESP(2)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .M00_AWADDR  (M00_AWADDR),
    .M00_AWVALID (M00_AWVALID),
    .M00_AWREADY (M00_AWREADY),
    .M00_WVALID  (M00_WVALID),
    .M00_WREADY  (M00_WREADY),
    .M00_BVALID  (M00_BVALID),
    .M00_BRESP   (M00_BRESP),
    .M00_BREADY  (M00_BREADY),
    .sel         (sel),
    .FWD_AWVALID (FWD_AWVALID),
    .FWD_WVALID  (FWD_WVALID),
    .FWD_BREADY  (FWD_BREADY),
    .S_AWREADY   (S_AWREADY),
    .S_WREADY    (S_WREADY),
    .S_BVALID    (S_BVALID),
    .S_BRESP     (S_BRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Expected B-channel outcome per transaction: {sel[2:0], bresp[1:0]}.
  logic [4:0] exp_q[$];

  // Reference state: last decodable index, and the tracked transaction.
  logic [2:0] model_sel = 3'd0;
  logic [2:0] cur_sel   = 3'd0;
  bit         cur_err   = 1'b0;
  bit         tb_aw_done = 1'b0;
  bit         tb_w_done  = 1'b0;
  int         phase = 0;      // 0 idle, 1 address/data, 2 response
  bit         track = 1'b0;   // per-cycle rule checks enabled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    M00_AWADDR  = '0;
    M00_AWVALID = 1'b0;
    M00_WVALID  = 1'b0;
    M00_BREADY  = 1'b0;
    S_AWREADY   = '0;
    S_WREADY    = '0;
    S_BVALID    = '0;
    S_BRESP     = '0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    drive_idle();
    exp_q.delete();
    model_sel = 3'd0;
    phase = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  task automatic noise();
    S_AWREADY = 6'($urandom);
    S_WREADY  = 6'($urandom);
    S_BVALID  = 6'($urandom);
    S_BRESP   = 12'($urandom);
  endtask

  // Scoreboard monitor plus per-cycle routing rules (random phase only).
  always @(negedge ACLK) begin
    logic [4:0] e;
    logic       exp_awr, exp_wr, exp_fa, exp_fw, exp_bv, exp_fb;
    logic [1:0] exp_br, slot_br;
    if (ARESETN) begin
      if (M00_BVALID && M00_BREADY) begin
        if (exp_q.size() == 0) begin
          check("b_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("b_sel", 32'(sel), 32'(e[4:2]));
          check("b_resp", 32'(M00_BRESP), 32'(e[1:0]));
        end
      end
      if (track) begin
        slot_br = S_BRESP[2*cur_sel +: 2];
        if (phase == 0) begin
          check("idle_outs", {M00_AWREADY, M00_WREADY, M00_BVALID, M00_BRESP,
                              FWD_AWVALID, FWD_WVALID, FWD_BREADY}, 32'd0);
        end else begin
          check("sel_hold", 32'(sel), 32'(cur_sel));
        end
        if (phase == 1) begin
          exp_awr = cur_err ? !tb_aw_done : (S_AWREADY[cur_sel] && !tb_aw_done);
          exp_wr  = cur_err ? !tb_w_done  : (S_WREADY[cur_sel]  && !tb_w_done);
          exp_fa  = !cur_err && M00_AWVALID && !tb_aw_done;
          exp_fw  = !cur_err && M00_WVALID  && !tb_w_done;
          check("data_ready", {M00_AWREADY, M00_WREADY}, {exp_awr, exp_wr});
          check("data_fwd", {FWD_AWVALID, FWD_WVALID}, {exp_fa, exp_fw});
          check("data_no_b", {M00_BVALID, M00_BRESP, FWD_BREADY}, 32'd0);
        end
        if (phase == 2) begin
          exp_bv = cur_err ? 1'b1  : S_BVALID[cur_sel];
          exp_br = cur_err ? 2'b11 : slot_br;
          exp_fb = !cur_err && M00_BREADY;
          check("resp_b", {M00_BVALID, M00_BRESP, FWD_BREADY}, {exp_bv, exp_br, exp_fb});
          check("resp_no_aw", {M00_AWREADY, M00_WREADY, FWD_AWVALID, FWD_WVALID}, 32'd0);
        end
      end
    end
  end

  // One complete write with randomized slave readiness and master timing.
  task automatic run_txn(input logic [2:0] idx);
    logic [1:0]  resp;
    bit          hs_aw, hs_w, hs_b;
    int unsigned cyc;
    resp    = 2'($urandom_range(3, 0));
    cur_err = (idx > 3'd5);
    cur_sel = cur_err ? model_sel : idx;
    if (!cur_err) model_sel = idx;
    exp_q.push_back({cur_sel, cur_err ? 2'b11 : resp});
    M00_AWADDR        = $urandom;
    M00_AWADDR[14:12] = idx;
    M00_AWVALID       = 1'b1;
    M00_WVALID        = 1'($urandom_range(1, 0));
    M00_BREADY        = 1'($urandom_range(1, 0));
    noise();
    @(posedge ACLK); #1;
    phase = 1;
    tb_aw_done = 1'b0;
    tb_w_done  = 1'b0;
    for (cyc = 0; cyc < 200 && !(tb_aw_done && tb_w_done); cyc++) begin
      noise();
      if (!tb_w_done && !M00_WVALID) M00_WVALID = 1'($urandom_range(1, 0));
      if (tb_aw_done) M00_AWADDR = $urandom;
      M00_BREADY = 1'($urandom_range(1, 0));
      @(negedge ACLK);
      hs_aw = M00_AWVALID && M00_AWREADY;
      hs_w  = M00_WVALID && M00_WREADY;
      @(posedge ACLK); #1;
      if (hs_aw) begin tb_aw_done = 1'b1; M00_AWVALID = 1'b0; end
      if (hs_w)  begin tb_w_done  = 1'b1; M00_WVALID  = 1'b0; end
    end
    check("aw_w_complete", {tb_aw_done, tb_w_done}, 32'd3);
    if (!(tb_aw_done && tb_w_done)) begin
      do_reset();
      return;
    end
    phase = 2;
    hs_b = 1'b0;
    for (cyc = 0; cyc < 200 && !hs_b; cyc++) begin
      noise();
      if (!cur_err) begin
        S_BVALID[cur_sel]       = 1'($urandom_range(1, 0));
        S_BRESP[2*cur_sel +: 2] = resp;
      end
      M00_AWADDR = $urandom;
      M00_BREADY = 1'($urandom_range(1, 0));
      @(negedge ACLK);
      hs_b = M00_BVALID && M00_BREADY;
      @(posedge ACLK); #1;
    end
    phase = 0;
    M00_BREADY = 1'b0;
    check("b_complete", 32'(hs_b), 32'd1);
    if (!hs_b) do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    drive_idle();

    // Reset held while the master requests: everything stays quiet, sel = 0.
    M00_AWVALID = 1'b1; M00_WVALID = 1'b1; M00_BREADY = 1'b1;
    S_AWREADY = '1; S_WREADY = '1; S_BVALID = '1; S_BRESP = '1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_outs", {M00_AWREADY, M00_WREADY, M00_BVALID, M00_BRESP,
                       FWD_AWVALID, FWD_WVALID, FWD_BREADY}, 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    M00_AWADDR = 32'h0000_0000;
    S_AWREADY = '0; S_WREADY = '0; S_BVALID = '0;
    @(negedge ACLK);
    check("rel_idle_fwd", {FWD_AWVALID, FWD_WVALID}, 32'd0);
    @(negedge ACLK);
    check("rel_data_fwd", {FWD_AWVALID, FWD_WVALID}, 32'd3);
    do_reset();

    // Routed write to slave 3, minimum-length transaction.
    M00_AWADDR = 32'h0000_3010; M00_AWVALID = 1'b1; M00_WVALID = 1'b1;
    S_AWREADY = 6'b001000; S_WREADY = 6'b001000;
    S_BRESP = '1; S_BRESP[7:6] = 2'b00;
    exp_q.push_back({3'd3, 2'b00});
    model_sel = 3'd3;
    @(posedge ACLK);
    @(negedge ACLK);
    check("rt_t1_sel", 32'(sel), 32'd3);
    check("rt_t1_hs", {M00_AWREADY, M00_WREADY, FWD_AWVALID, FWD_WVALID}, 32'hF);
    @(posedge ACLK); #1;
    M00_AWVALID = 1'b0; M00_WVALID = 1'b0;
    S_BVALID = 6'b001000; M00_BREADY = 1'b1;
    @(negedge ACLK);
    check("rt_t2_b", {M00_BVALID, M00_BRESP, FWD_BREADY, M00_AWREADY}, 32'b10010);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("rt_t3_idle", {M00_BVALID, M00_BRESP, FWD_BREADY, M00_AWREADY}, 32'd0);
    @(posedge ACLK); #1;
    drive_idle();

    // W completes first; AW accepted two cycles later.
    M00_AWADDR = 32'h0000_1000; M00_AWVALID = 1'b1; M00_WVALID = 1'b1;
    S_WREADY = 6'b000010;
    S_BRESP = '1; S_BRESP[3:2] = 2'b01;
    exp_q.push_back({3'd1, 2'b01});
    model_sel = 3'd1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("wf_t1", {M00_WREADY, M00_AWREADY, FWD_WVALID}, 32'b101);
    @(negedge ACLK);
    check("wf_t2", {M00_WREADY, M00_AWREADY, FWD_WVALID}, 32'b000);
    @(posedge ACLK); #1;
    S_AWREADY = 6'b000010;
    @(negedge ACLK);
    check("wf_t3", {M00_WREADY, M00_AWREADY, FWD_WVALID, M00_BVALID}, 32'b0100);
    @(posedge ACLK); #1;
    M00_AWVALID = 1'b0; M00_WVALID = 1'b0;
    S_BVALID = 6'b000010; M00_BREADY = 1'b1;
    @(negedge ACLK);
    check("wf_t4_b", {M00_BVALID, M00_BRESP}, 32'b101);
    @(posedge ACLK); #1;
    drive_idle();

    // Slave 0 raises BVALID early; nothing reaches the master until RESP.
    M00_AWADDR = 32'h0000_0ABC; M00_AWVALID = 1'b1; M00_WVALID = 1'b1;
    S_BVALID = 6'b000001; S_BRESP = '1; S_BRESP[1:0] = 2'b10; M00_BREADY = 1'b1;
    exp_q.push_back({3'd0, 2'b10});
    model_sel = 3'd0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("early_b1", {M00_BVALID, M00_BRESP, FWD_BREADY}, 32'd0);
    @(negedge ACLK);
    check("early_b2", {M00_BVALID, M00_BRESP, FWD_BREADY}, 32'd0);
    @(posedge ACLK); #1;
    S_AWREADY = 6'b000001; S_WREADY = 6'b000001;
    @(negedge ACLK);
    check("early_hs", {M00_AWREADY, M00_WREADY, M00_BVALID}, 32'b110);
    @(posedge ACLK); #1;
    M00_AWVALID = 1'b0; M00_WVALID = 1'b0;
    @(negedge ACLK);
    check("early_resp", {M00_BVALID, M00_BRESP, FWD_BREADY}, 32'b1101);
    @(posedge ACLK); #1;
    drive_idle();

    // Establish sel = 2, then an undecodable index 7.
    run_txn(3'd2);
    drive_idle();
    M00_AWADDR = 32'h0000_7000; M00_AWVALID = 1'b1; M00_WVALID = 1'b1;
    S_AWREADY = '1; S_WREADY = '1;
    exp_q.push_back({3'd2, 2'b11});
    @(posedge ACLK);
    @(negedge ACLK);
    check("de_sel", 32'(sel), 32'd2);
    check("de_t1", {M00_AWREADY, M00_WREADY, FWD_AWVALID, FWD_WVALID}, 32'b1100);
    @(posedge ACLK); #1;
    M00_AWVALID = 1'b0; M00_WVALID = 1'b0; S_BVALID = '1; S_BRESP = '0;
    @(negedge ACLK);
    check("de_t2", {M00_BVALID, M00_BRESP, FWD_BREADY}, 32'b1110);
    @(negedge ACLK);
    check("de_hold", {M00_BVALID, M00_BRESP}, 32'b111);
    @(posedge ACLK); #1;
    M00_BREADY = 1'b1;
    @(negedge ACLK);
    check("de_fwd_bready", {FWD_BREADY, M00_BVALID, sel}, 32'b01010);
    @(posedge ACLK); #1;
    drive_idle();

    // Reset while a response is pending.
    M00_AWADDR = 32'h0000_4000; M00_AWVALID = 1'b1; M00_WVALID = 1'b1;
    S_AWREADY = 6'b010000; S_WREADY = 6'b010000;
    S_BRESP = '0; S_BRESP[9:8] = 2'b01;
    exp_q.push_back({3'd4, 2'b01});
    @(posedge ACLK);
    @(posedge ACLK); #1;
    M00_AWVALID = 1'b0; M00_WVALID = 1'b0; S_BVALID = 6'b010000;
    @(negedge ACLK);
    check("mr_pending", {M00_BVALID, M00_BRESP, sel}, 32'b101100);
    #1;
    ARESETN = 1'b0;
    M00_BREADY = 1'b1;
    exp_q.delete();
    model_sel = 3'd0;
    #1;
    check("mr_async", {M00_BVALID, M00_BRESP, FWD_BREADY, sel}, 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    M00_BREADY = 1'b0;
    S_AWREADY = '1; S_WREADY = '1; S_BVALID = '1;
    @(negedge ACLK);
    check("mr_idle", {M00_AWREADY, M00_WREADY, M00_BVALID, FWD_BREADY}, 32'd0);
    do_reset();

    // Randomized transactions with per-cycle rule checking.
    track = 1'b1;
    for (int i = 0; i < 200; i++) begin
      run_txn(3'($urandom_range(7, 0)));
      M00_AWVALID = 1'b0;
      M00_WVALID  = 1'b0;
      repeat ($urandom_range(2, 0)) begin
        noise();
        M00_BREADY = 1'($urandom_range(1, 0));
        @(posedge ACLK); #1;
      end
      M00_BREADY = 1'b0;
    end
    track = 1'b0;
    drive_idle();
    @(negedge ACLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/write_route_ctrl.md
# write_route_ctrl

Write-channel routing controller for the AXI4-Lite interconnect, directly upstream of the write demultiplexer. It decodes the master's AWADDR into a slave index, drives the demultiplexer select, and holds that select stable for the whole AW/W/B transaction. It gates the master's AWVALID, WVALID and BREADY before they reach the demux, and returns the selected slave's AWREADY, WREADY, BVALID and BRESP to the master. Addresses outside slaves 0-5 complete locally with DECERR.

## Interface
- ADDR, 32, AWADDR width
- SLOT_LSB, 12, lowest AWADDR bit of the 3-bit slave index field AWADDR[SLOT_LSB+2:SLOT_LSB]
- RESP, 2, BRESP width
- ACLK  in  1  clock; all state updates on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- M00_AWADDR  in  ADDR  master write address; only the index field is used
- M00_AWVALID  in  1  master address valid
- M00_AWREADY  out  1  address ready to master
- M00_WVALID  in  1  master data valid
- M00_WREADY  out  1  data ready to master
- M00_BVALID  out  1  response valid to master
- M00_BRESP  out  RESP  response to master
- M00_BREADY  in  1  master response ready
- sel  out  3  demux select, registered
- FWD_AWVALID  out  1  gated AWVALID into the demux
- FWD_WVALID  out  1  gated WVALID into the demux
- FWD_BREADY  out  1  gated BREADY into the demux
- S_AWREADY  in  6  AWREADY of slaves 0-5; bit i belongs to slave i
- S_WREADY  in  6  WREADY of slaves 0-5
- S_BVALID  in  6  BVALID of slaves 0-5
- S_BRESP  in  6*RESP  BRESP of slaves 0-5; slave i occupies [RESP*i +: RESP]

## Operation
- States: IDLE, DATA, RESP. Registers: state, sel, err, aw_done, w_done.
- IDLE
  - All M00 ready/valid outputs and FWD_* outputs are 0.
  - When M00_AWVALID=1 at a clock edge, let idx = the index field:
    - idx ≤ 5: sel←idx, err←0.
    - idx is 6 or 7: err←1, sel unchanged.
  - On that same edge: clear aw_done and w_done, go to DATA.
- DATA, err=0
  - FWD_AWVALID = M00_AWVALID & ~aw_done.
  - FWD_WVALID = M00_WVALID & ~w_done.
  - M00_AWREADY = S_AWREADY[sel] & ~aw_done.
  - M00_WREADY = S_WREADY[sel] & ~w_done.
- DATA, err=1
  - FWD_* outputs are 0.
  - M00_AWREADY = ~aw_done.
  - M00_WREADY = ~w_done.
- aw_done is set by the AW handshake (M00_AWVALID & M00_AWREADY); w_done is set by the W handshake.
- AW and W complete in either order or in the same cycle.
- Leave DATA for RESP on the edge where both handshakes are complete, counting a handshake that occurs on that edge.
- RESP, err=0
  - M00_BVALID = S_BVALID[sel].
  - M00_BRESP = S_BRESP[sel].
  - FWD_BREADY = M00_BREADY.
- RESP, err=1
  - M00_BVALID = 1, M00_BRESP = 2'b11 (DECERR), FWD_BREADY = 0.
- Leave RESP for IDLE on M00_BVALID & M00_BREADY.
- M00_BRESP is 0 whenever the block is not in RESP.
- sel changes only on the IDLE→DATA edge of a decodable address, so it is constant from DATA entry through the B handshake.
- A slave raising BVALID before RESP is not acknowledged (FWD_BREADY=0); it must hold BVALID per AXI.
- Reset asserted at any time: state←IDLE, sel←0, err, aw_done and w_done←0.
  - All outputs go to 0 immediately.
  - An in-flight transaction is abandoned; masters and slaves are reset together at system level.

## Timing
- M00 ready/valid/resp outputs and FWD_* outputs are combinational from registered state and slave/master inputs; there is no registered data path.
- Address-decode latency is 1 cycle: AWVALID sampled in IDLE at edge T0 → earliest AW and W handshake in cycle T0+1.
- Minimum transaction: IDLE at T0, DATA at T1 (AW+W handshake), RESP at T2 (B handshake), IDLE at T3. Peak rate is one write per 3 cycles.
- After the B handshake, a new AWVALID is sampled at the first edge in IDLE.
- FWD_AWVALID never rises in the same cycle sel changes.

## Test plan
- Reset: ARESETN=0 while M00_AWVALID=1 → sel=0, all ready/valid outputs 0. Release: IDLE→DATA on first edge with M00_AWVALID=1.
- Routed write: AWADDR=0x0000_3010 (idx 3), S_AWREADY=S_WREADY=6'b001000, slave 3 BVALID with BRESP=0 →
  - sel=3 from T1; AW+W handshake at T1; M00_BVALID=1, BRESP=0 at T2; IDLE at T3.
- W before AW: idx 1, S_WREADY[1]=1 at T1, S_AWREADY[1]=1 only at T3 →
  - M00_WREADY=1 in T1 only; FWD_WVALID=0 at T2-T3; RESP at T4.
- Decode error: AWADDR=0x0000_7000 (idx 7), previous sel=2 →
  - sel stays 2; FWD_* all 0; AWREADY=WREADY=1 at T1; M00_BVALID=1, BRESP=2'b11 at T2, held until BREADY.
- Early slave response: S_BVALID[0]=1 during DATA → FWD_BREADY=0 and M00_BVALID=0 until RESP.
- Mid-transaction reset: assert ARESETN=0 in RESP with BVALID pending → outputs 0 asynchronously; state IDLE after release.
